sound_sequencer: RTL and testbench

- Sits between the game event sources (good collision, bad collision, direction change) and the shared tone oscillator / DAC path.
- Arbitrates event requests and latches requests that arrive while a note is playing.
- Sequences one note at a time: drives a frequency word and a play enable for a fixed per-event duration, with a one-cycle silent gap between notes.
- Owns the sound on/off (mute) mode.

---
 rtl/sound_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_sound_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// sound_sequencer
//   Arbitrates game sound events (bad collision > good collision > direction
//   change), queues requests that arrive while a note plays, and sequences
//   one note at a time toward the shared tone oscillator. Each note lasts a
//   fixed per-source duration and is followed by a one-cycle silent gap.
//   The block also holds the sound on/off (mute) mode.
//
//   Optional build macro: SOUND_PREEMPT_EN. When it is defined, a strictly
//   higher-priority request aborts the current note (via one gap cycle).
//
// Ports:
//   clk         system clock
//   nRst        asynchronous active-low reset
//   goodColl    good-collision request pulse
//   badColl     bad-collision request pulse
//   direction   direction-change pulses; any bit set is one request
//   muteToggle  flips the mute mode
//   freq        tone frequency in Hz, 0 when silent
//   playSound   oscillator enable
//   busy        high while playing a note or in the gap after it
//   muted       1 = sound off
//   noteId      0 none, 1 dir, 2 good, 3 bad
module sound_sequencer #(
  parameter int unsigned DUR_GOOD = 20,
  parameter int unsigned DUR_BAD  = 30,
  parameter int unsigned DUR_DIR  = 5,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic [3:0] direction,
  input  logic       muteToggle,
  output logic [8:0] freq,
  output logic       playSound,
  output logic       busy,
  output logic       muted,
  output logic [1:0] noteId
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam logic [8:0] F_DIR  = 9'd262;
  localparam logic [8:0] F_GOOD = 9'd440;
  localparam logic [8:0] F_BAD  = 9'd311;

  state_t           state_q, state_d;
  logic [2:0]       pending_q, pending_d;  // {bad, good, dir}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             muted_q, muted_d;
  logic [8:0]       freq_q, freq_d;
  logic             play_q, play_d;
  logic             busy_q, busy_d;
  logic [1:0]       id_q, id_d;

  logic [2:0]       req_eff;
  logic [2:0]       avail;
  logic [1:0]       top_id;
  logic [8:0]       g_freq;
  logic [CNT_W-1:0] g_cnt;
  logic [2:0]       g_mask;

  // Requests are dropped while muted and in any cycle that toggles mute.
  always_comb begin
    req_eff = '0;
    if (!muted_q && !muteToggle) begin
      req_eff = {badColl, goodColl, |direction};
    end
    avail = pending_q | req_eff;

    // noteId encoding doubles as priority rank.
    if (avail[2])      top_id = 2'd3;
    else if (avail[1]) top_id = 2'd2;
    else if (avail[0]) top_id = 2'd1;
    else               top_id = 2'd0;

    case (top_id)
      2'd3:    begin g_freq = F_BAD;  g_cnt = CNT_W'(DUR_BAD - 1);  g_mask = 3'b100; end
      2'd2:    begin g_freq = F_GOOD; g_cnt = CNT_W'(DUR_GOOD - 1); g_mask = 3'b010; end
      2'd1:    begin g_freq = F_DIR;  g_cnt = CNT_W'(DUR_DIR - 1);  g_mask = 3'b001; end
      default: begin g_freq = '0;     g_cnt = '0;                   g_mask = 3'b000; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    muted_d   = muted_q;
    freq_d    = freq_q;
    play_d    = play_q;
    busy_d    = busy_q;
    id_d      = id_q;

    if (muteToggle || muted_q) begin
      // Entering or leaving mute, or sitting muted: silent and empty.
      if (muteToggle) muted_d = ~muted_q;
      state_d   = IDLE;
      pending_d = '0;
      cnt_d     = '0;
      freq_d    = '0;
      play_d    = 1'b0;
      busy_d    = 1'b0;
      id_d      = 2'd0;
    end else begin
      pending_d = avail;
      case (state_q)
        PLAY: begin
`ifdef SOUND_PREEMPT_EN
          if (top_id > id_q || cnt_q == '0) begin
`else
          if (cnt_q == '0) begin
`endif
            state_d = GAP;
            cnt_d   = '0;
            freq_d  = '0;
            play_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        IDLE, GAP: begin
          if (top_id != 2'd0) begin
            state_d   = PLAY;
            pending_d = avail & ~g_mask;
            cnt_d     = g_cnt;
            freq_d    = g_freq;
            play_d    = 1'b1;
            busy_d    = 1'b1;
            id_d      = top_id;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            freq_d  = '0;
            play_d  = 1'b0;
            busy_d  = 1'b0;
            id_d    = 2'd0;
          end
        end
        default: begin
          state_d   = IDLE;
          pending_d = '0;
          cnt_d     = '0;
          freq_d    = '0;
          play_d    = 1'b0;
          busy_d    = 1'b0;
          id_d      = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      muted_q   <= 1'b0;
      freq_q    <= '0;
      play_q    <= 1'b0;
      busy_q    <= 1'b0;
      id_q      <= 2'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      muted_q   <= muted_d;
      freq_q    <= freq_d;
      play_q    <= play_d;
      busy_q    <= busy_d;
      id_q      <= id_d;
    end
  end

  assign freq      = freq_q;
  assign playSound = play_q;
  assign busy      = busy_q;
  assign muted     = muted_q;
  assign noteId    = id_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Testbench for sound_sequencer: per-cycle expected outputs are queued when
// stimulus is applied and compared one entry per clock cycle.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       nRst;
  logic       goodColl, badColl, muteToggle;
  logic [3:0] direction;
  logic [8:0] freq;
  logic       playSound, busy, muted;
  logic [1:0] noteId;

  typedef struct packed {
    logic [8:0] f;
    logic       p;
    logic       b;
    logic       m;
    logic [1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  sound_sequencer #(
    .DUR_GOOD(20),
    .DUR_BAD (30),
    .DUR_DIR (5),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .goodColl  (goodColl),
    .badColl   (badColl),
    .direction (direction),
    .muteToggle(muteToggle),
    .freq      (freq),
    .playSound (playSound),
    .busy      (busy),
    .muted     (muted),
    .noteId    (noteId)
  );

  always #5 clk = ~clk;

  task automatic push_note(input logic [8:0] f, input logic [1:0] id, input int n);
    exp_t e;
    e = '{f: f, p: 1'b1, b: 1'b1, m: 1'b0, id: id};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_gap(input logic [1:0] id);
    exp_t e;
    e = '{f: 9'd0, p: 1'b0, b: 1'b1, m: 1'b0, id: id};
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input logic m, input int n);
    exp_t e;
    e = '{f: 9'd0, p: 1'b0, b: 1'b0, m: m, id: 2'd0};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One clock: inputs set before the call are sampled at this edge, then
  // cleared so every request is a single-cycle pulse.
  task automatic step(input string name);
    exp_t e, o;
    @(posedge clk);
    #1;
    cyc++;
    goodColl = 1'b0; badColl = 1'b0; direction = 4'b0000; muteToggle = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = '{f: freq, p: playSound, b: busy, m: muted, id: noteId};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got freq=%0d play=%b busy=%b muted=%b id=%0d, want freq=%0d play=%b busy=%b muted=%b id=%0d",
                 name, cyc, o.f, o.p, o.b, o.m, o.id, e.f, e.p, e.b, e.m, e.id);
      end
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      step(name);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d entries left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    goodColl = 1'b0; badColl = 1'b0; direction = 4'b0000; muteToggle = 1'b0;
    #12;
    n_checks++;
    if ({freq, playSound, busy, muted, noteId} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset: got %h, want 0", {freq, playSound, busy, muted, noteId});
    end
    @(negedge clk);
    nRst = 1'b1;
    push_idle(1'b0, 2);
    drain("reset_idle");
  endtask

  task automatic test_good();
    goodColl = 1'b1;
    push_note(9'd440, 2'd2, 20);
    push_gap(2'd2);
    push_idle(1'b0, 2);
    drain("good");
  endtask

  task automatic test_simultaneous();
    goodColl = 1'b1; badColl = 1'b1; direction = 4'b0100;
    push_note(9'd311, 2'd3, 30); push_gap(2'd3);
    push_note(9'd440, 2'd2, 20); push_gap(2'd2);
    push_note(9'd262, 2'd1, 5);  push_gap(2'd1);
    push_idle(1'b0, 2);
    drain("simultaneous");
  endtask

  task automatic test_coalesce();
    push_note(9'd262, 2'd1, 5); push_gap(2'd1);
    push_note(9'd262, 2'd1, 5); push_gap(2'd1);
    push_idle(1'b0, 3);
    direction = 4'b0001; step("coalesce");
    direction = 4'b0010; step("coalesce");
    direction = 4'b1000; step("coalesce");
    direction = 4'b0001; step("coalesce");
    drain("coalesce");
  endtask

  // Request landing in the gap cycle goes straight back into PLAY; a request
  // at the last PLAY cycle replays after the gap.
  task automatic test_back_to_back();
    push_note(9'd440, 2'd2, 20); push_gap(2'd2);
    push_note(9'd440, 2'd2, 20); push_gap(2'd2);
    push_note(9'd311, 2'd3, 30); push_gap(2'd3);
    push_idle(1'b0, 2);
    goodColl = 1'b1;
    step("b2b");
    repeat (20) step("b2b");
    goodColl = 1'b1;                 // sampled leaving the gap
    step("b2b");
    repeat (19) step("b2b");
    badColl = 1'b1;                  // sampled leaving the last PLAY cycle
    drain("b2b");
  endtask

  task automatic test_mute();
    push_note(9'd440, 2'd2, 3);
    goodColl = 1'b1;
    repeat (3) step("mute_note");
    muteToggle = 1'b1;
    push_idle(1'b1, 1);
    step("mute_on");
    push_idle(1'b1, 3);
    badColl = 1'b1;
    repeat (3) step("mute_discard");
    muteToggle = 1'b1; badColl = 1'b1;
    push_idle(1'b0, 3);
    repeat (3) step("unmute_same_cycle");
    muteToggle = 1'b1; goodColl = 1'b1;
    push_idle(1'b1, 2);
    repeat (2) step("mute_same_cycle");
    muteToggle = 1'b1;
    push_idle(1'b0, 2);
    drain("unmute");
  endtask

  task automatic test_reset_mid();
    push_note(9'd311, 2'd3, 5);
    badColl = 1'b1; step("rst_mid");
    step("rst_mid");
    goodColl = 1'b1; step("rst_mid");
    step("rst_mid");
    step("rst_mid");
    #2;
    nRst = 1'b0;
    #1;
    n_checks++;
    if ({freq, playSound, busy, muted, noteId} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid async: got %h, want 0", {freq, playSound, busy, muted, noteId});
    end
    @(negedge clk);
    nRst = 1'b1;
    push_idle(1'b0, 5);
    drain("rst_after");
  endtask

  task automatic test_preempt();
`ifdef SOUND_PREEMPT_EN
    push_note(9'd262, 2'd1, 2); push_gap(2'd1);
`else
    push_note(9'd262, 2'd1, 5); push_gap(2'd1);
`endif
    push_note(9'd311, 2'd3, 30); push_gap(2'd3);
    push_idle(1'b0, 3);
    direction = 4'b0001;
    step("preempt");
    step("preempt");
    badColl = 1'b1;
    drain("preempt");
  endtask

  initial begin
    test_reset();
    test_good();
    test_simultaneous();
    test_coalesce();
    test_back_to_back();
    test_mute();
    test_reset_mid();
    test_preempt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
